basket_game_ctrl: RTL and testbench

Game controller for the basketball scoring machine: consumes the one-cycle start, stop and goal pulses from the input conditioning chain and a 1 Hz tick from the clock divider. It runs the ready / play / pause / over sequence and keeps a BCD score and a BCD countdown. It drives the score and timer digits for the seven-segment scanner and VGA renderer, the game state code, and the buzzer enable.

---
 rtl/basket_game_ctrl.sv | 170 +++++++++++++++++
 tb/tb_basket_game_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/basket_game_ctrl.sv
// basket_game_ctrl
// Game sequencer for the basketball scoring machine. Runs the
// IDLE -> READY -> PLAY <-> PAUSE -> OVER sequence and keeps a two-digit
// BCD score and a two-digit BCD countdown. It also times the buzzer.
//
// Ports
//   clk       system clock, all state on the rising edge
//   rst       synchronous active-high reset, overrides every other input
//   tick_1hz  one-cycle pulse per second
//   start_p   one-cycle start pulse
//   stop_p    one-cycle stop/pause pulse
//   goal_p    one-cycle goal pulse
//   score0/1  score ones/tens digit, BCD
//   cnt0/1    countdown ones/tens digit, BCD
//   state     0 IDLE, 1 READY, 2 PLAY, 3 PAUSE, 4 OVER
//   buzz      buzzer enable, high while the buzz timer is nonzero
module basket_game_ctrl #(
  parameter int unsigned GAME_SEC  = 60,
  parameter int unsigned READY_SEC = 3,
  parameter int unsigned BEEP_CYC  = 10_000_000,
  parameter int unsigned END_CYC   = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       start_p,
  input  logic       stop_p,
  input  logic       goal_p,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic [3:0] cnt0,
  output logic [3:0] cnt1,
  output logic [2:0] state,
  output logic       buzz
);

  localparam int unsigned BuzzMax = (END_CYC > BEEP_CYC) ? END_CYC : BEEP_CYC;
  localparam int unsigned BuzzW   = $clog2(BuzzMax + 1);

  localparam logic [BuzzW-1:0] BeepLoad = BuzzW'(BEEP_CYC);
  localparam logic [BuzzW-1:0] EndLoad  = BuzzW'(END_CYC);

  // {tens, ones} BCD images of the load values
  localparam logic [7:0] GameBcd  = {4'(GAME_SEC / 10), 4'(GAME_SEC % 10)};
  localparam logic [7:0] ReadyBcd = {4'd0, 4'(READY_SEC)};

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReady = 3'd1,
    StPlay  = 3'd2,
    StPause = 3'd3,
    StOver  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       score_q, score_d;
  logic [BuzzW-1:0] timer_q, timer_d;

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) begin
      return {v[7:4] - 4'd1, 4'd9};
    end
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    score_d = score_q;
    timer_d = (timer_q != '0) ? timer_q - BuzzW'(1) : '0;

    case (state_q)
      StIdle: begin
        // stop_p wins over a simultaneous start_p
        if (start_p && !stop_p) begin
          state_d = StReady;
          cnt_d   = ReadyBcd;
          score_d = 8'h00;
        end
      end
      StReady: begin
        if (stop_p) begin
          state_d = StIdle;
          cnt_d   = GameBcd;
        end else if (tick_1hz) begin
          if (cnt_q == 8'h01) begin
            state_d = StPlay;
            cnt_d   = GameBcd;
          end else begin
            cnt_d = bcd_dec(cnt_q);
          end
        end
      end
      StPlay: begin
        // A goal at 99 is not counted and does not beep
        if (goal_p && score_q != 8'h99) begin
          score_d = bcd_inc(score_q);
          timer_d = BeepLoad;
        end
        // The final tick beats a simultaneous stop_p
        if (tick_1hz && cnt_q == 8'h01) begin
          state_d = StOver;
          cnt_d   = 8'h00;
          timer_d = EndLoad;
        end else begin
          if (tick_1hz) cnt_d = bcd_dec(cnt_q);
          if (stop_p) state_d = StPause;
        end
      end
      StPause: begin
        if (stop_p) begin
          state_d = StIdle;
          score_d = 8'h00;
          cnt_d   = GameBcd;
        end else if (start_p) begin
          state_d = StPlay;
        end
      end
      StOver: begin
        if (stop_p) begin
          state_d = StIdle;
          cnt_d   = GameBcd;
        end else if (start_p) begin
          state_d = StReady;
          score_d = 8'h00;
          cnt_d   = ReadyBcd;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = GameBcd;
        score_d = 8'h00;
        timer_d = '0;
      end
    endcase

    // The buzzer is silenced whenever the game is (or goes) idle
    if (state_d == StIdle) timer_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= GameBcd;
      score_q <= 8'h00;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      score_q <= score_d;
      timer_q <= timer_d;
    end
  end

  assign score0 = score_q[3:0];
  assign score1 = score_q[7:4];
  assign cnt0   = cnt_q[3:0];
  assign cnt1   = cnt_q[7:4];
  assign state  = state_q;
  assign buzz   = (timer_q != '0);

endmodule

// File: tb/tb_basket_game_ctrl.sv
// Bench for basket_game_ctrl: directed scenarios followed by random pulses,
// every cycle compared against an integer model of the game rules.
module tb_basket_game_ctrl;

  localparam int GameSec  = 5;
  localparam int ReadySec = 3;
  localparam int BeepCyc  = 4;
  localparam int EndCyc   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       start_p = 1'b0;
  logic       stop_p = 1'b0;
  logic       goal_p = 1'b0;
  logic [3:0] score0, score1, cnt0, cnt1;
  logic [2:0] state;
  logic       buzz;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain integers (seconds, points, cycles)
  int m_state = 0;
  int m_score = 0;
  int m_cnt   = GameSec;
  int m_timer = 0;
  int phase   = 0;

  basket_game_ctrl #(
    .GAME_SEC (GameSec),
    .READY_SEC(ReadySec),
    .BEEP_CYC (BeepCyc),
    .END_CYC  (EndCyc)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .tick_1hz(tick_1hz),
    .start_p (start_p),
    .stop_p  (stop_p),
    .goal_p  (goal_p),
    .score0  (score0),
    .score1  (score1),
    .cnt0    (cnt0),
    .cnt1    (cnt1),
    .state   (state),
    .buzz    (buzz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step(input bit r, input bit tk, input bit s, input bit p,
                                     input bit g);
    int t;
    if (r) begin
      m_state = 0; m_score = 0; m_cnt = GameSec; m_timer = 0;
      return;
    end
    t = (m_timer > 0) ? m_timer - 1 : 0;
    case (m_state)
      0: if (s && !p) begin m_state = 1; m_cnt = ReadySec; m_score = 0; end
      1: begin
        if (p) begin
          m_state = 0; m_cnt = GameSec;
        end else if (tk) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin m_state = 2; m_cnt = GameSec; end
        end
      end
      2: begin
        if (g && m_score < 99) begin m_score++; t = BeepCyc; end
        if (tk) m_cnt = m_cnt - 1;
        if (tk && m_cnt == 0) begin
          m_state = 4; t = EndCyc;
        end else if (p) begin
          m_state = 3;
        end
      end
      3: begin
        if (p) begin
          m_state = 0; m_score = 0; m_cnt = GameSec;
        end else if (s) begin
          m_state = 2;
        end
      end
      default: begin
        if (p) begin
          m_state = 0; m_cnt = GameSec;
        end else if (s) begin
          m_state = 1; m_score = 0; m_cnt = ReadySec;
        end
      end
    endcase
    if (m_state == 0) t = 0;
    m_timer = t;
  endfunction

  // One clock: apply pulses, update the model at the edge, compare #1 later
  task automatic cyc(input bit r, input bit tk, input bit s, input bit p, input bit g);
    rst = r; tick_1hz = tk; start_p = s; stop_p = p; goal_p = g;
    @(posedge clk);
    model_step(r, tk, s, p, g);
    #1;
    rst = 1'b0; tick_1hz = 1'b0; start_p = 1'b0; stop_p = 1'b0; goal_p = 1'b0;
    check("state", 32'(state), 32'(m_state));
    check("score1", 32'(score1), 32'(m_score / 10));
    check("score0", 32'(score0), 32'(m_score % 10));
    check("cnt1", 32'(cnt1), 32'(m_cnt / 10));
    check("cnt0", 32'(cnt0), 32'(m_cnt % 10));
    check("buzz", 32'(buzz), 32'(m_timer != 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      idle(2);
      cyc(0, 1, 0, 0, 0);
    end
  endtask

  initial begin
    int nb;

    // Reset state
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("rst_state", 32'(state), 0);
    check("rst_cnt", 32'({cnt1, cnt0}), 32'h05);
    check("rst_buzz", 32'(buzz), 0);

    // Goal in IDLE ignored, then start
    cyc(0, 0, 0, 0, 1);
    check("idle_goal", 32'({score1, score0}), 32'h00);
    cyc(0, 0, 1, 0, 0);
    check("ready_state", 32'(state), 1);
    check("ready_cnt", 32'({cnt1, cnt0}), 32'h03);
    cyc(0, 0, 0, 0, 1);
    tick_n(3);
    check("play_state", 32'(state), 2);
    check("play_cnt", 32'({cnt1, cnt0}), 32'h05);

    // Pause holds count and score
    tick_n(2);
    cyc(0, 0, 0, 1, 0);
    tick_n(3);
    cyc(0, 0, 0, 0, 1);
    check("pause_state", 32'(state), 3);
    check("pause_cnt", 32'({cnt1, cnt0}), 32'h03);
    check("pause_score", 32'({score1, score0}), 32'h00);
    cyc(0, 0, 1, 0, 0);
    check("resume_state", 32'(state), 2);
    tick_n(1);
    check("resume_cnt", 32'({cnt1, cnt0}), 32'h02);

    // Goal on the final tick: counts, OVER, long buzz
    tick_n(1);
    cyc(0, 1, 0, 0, 1);
    check("final_state", 32'(state), 4);
    check("final_score", 32'({score1, score0}), 32'h01);
    check("final_cnt", 32'({cnt1, cnt0}), 32'h00);
    nb = buzz ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0, 0, i == 5);
      if (buzz) nb++;
    end
    check("end_buzz_len", 32'(nb), 32'(EndCyc));
    check("over_goal", 32'({score1, score0}), 32'h01);

    // Restart, 12 goals two cycles apart, then saturate (no ticks meanwhile)
    cyc(0, 0, 1, 0, 0);
    tick_n(3);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
    end
    check("score12", 32'({score1, score0}), 32'h12);
    for (int i = 0; i < 99; i++) cyc(0, 0, 0, 0, 1);
    check("score99", 32'({score1, score0}), 32'h99);
    idle(6);

    // start+stop together in PAUSE: stop wins
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0);
    check("startstop", 32'(state), 0);

    // Reset mid-PLAY while buzzing
    cyc(0, 0, 1, 0, 0);
    tick_n(3);
    cyc(0, 0, 0, 0, 1);
    check("pre_rst_buzz", 32'(buzz), 1);
    cyc(1, 0, 0, 0, 0);
    check("mid_rst_state", 32'(state), 0);
    check("mid_rst_score", 32'({score1, score0}), 32'h00);
    check("mid_rst_cnt", 32'({cnt1, cnt0}), 32'h05);
    check("mid_rst_buzz", 32'(buzz), 0);

    // Random pulses with a free-running 20-cycle tick
    for (int i = 0; i < 4000; i++) begin
      phase = (phase + 1) % 20;
      cyc($urandom_range(999) == 0, phase == 0, $urandom_range(29) == 0,
          $urandom_range(59) == 0, $urandom_range(7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
